// File: rtl/aes_input_loader.sv
// aes_input_loader: streams plaintext and key in over a DIN_W-wide beat bus,
// then launches the AES engine with a start/done handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | accepting commands, no load in progress
// LOADP    | shifting SP beats into the plaintext register
// LOADK    | shifting SK beats into the key register
// BUSY_ACK | start issued, waiting for the engine to drop transformer_done
// BUSY_RUN | engine running, waiting for transformer_done to return high
module aes_input_loader #(
    parameter int DIN_W    = 8,
    parameter int KEY_W    = 128,
    parameter int KEEP_KEY = 1
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [DIN_W-1:0] din,
    input  logic [1:0]       cmd,
    input  logic             transformer_done,
    output logic             ready,
    output logic             engine_start,
    output logic [127:0]     plain_out,
    output logic [KEY_W-1:0] key_out,
    output logic             plain_valid,
    output logic             key_valid,
    output logic             done_pulse,
    output logic [1:0]       err
);

    localparam int PB  = 128 / DIN_W;
    localparam int KB  = KEY_W / DIN_W;
    localparam int PCW = $clog2(PB + 1);
    localparam int KCW = $clog2(KB + 1);
    localparam logic [PCW-1:0] PB_C = PCW'(PB);
    localparam logic [KCW-1:0] KB_C = KCW'(KB);

    localparam logic [1:0] CMD_ID = 2'b00;
    localparam logic [1:0] CMD_SP = 2'b01;
    localparam logic [1:0] CMD_SK = 2'b10;
    localparam logic [1:0] CMD_ST = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOADP    = 3'd1,
        LOADK    = 3'd2,
        BUSY_ACK = 3'd3,
        BUSY_RUN = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [127:0]       plain_q, plain_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [PCW-1:0]     pcnt_q, pcnt_d;
    logic [KCW-1:0]     kcnt_q, kcnt_d;
    logic               pv_q, pv_d;
    logic               kv_q, kv_d;
    logic [1:0]         err_q, err_d;
    logic               start_q, start_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;

    // Register all state and outputs; reset returns everything to zero/IDLE.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state_q <= IDLE;
            plain_q <= '0;
            key_q   <= '0;
            pcnt_q  <= '0;
            kcnt_q  <= '0;
            pv_q    <= 1'b0;
            kv_q    <= 1'b0;
            err_q   <= 2'b00;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            plain_q <= plain_d;
            key_q   <= key_d;
            pcnt_q  <= pcnt_d;
            kcnt_q  <= kcnt_d;
            pv_q    <= pv_d;
            kv_q    <= kv_d;
            err_q   <= err_d;
            start_q <= start_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    // Next-state, beat assembly and handshake decode.
    always_comb begin
        state_d = state_q;
        plain_d = plain_q;
        key_d   = key_q;
        pcnt_d  = pcnt_q;
        kcnt_d  = kcnt_q;
        pv_d    = pv_q;
        kv_d    = kv_q;
        err_d   = err_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE, LOADP, LOADK: begin
                unique case (cmd)
                    CMD_ID: state_d = IDLE;
                    CMD_SP: begin
                        state_d = LOADP;
                        // A fresh load restarts the count; this edge's beat is beat one.
                        if (state_q != LOADP) begin
                            pcnt_d = '0;
                            pv_d   = 1'b0;
                        end
                        if (pcnt_d < PB_C) begin
                            plain_d = {plain_q[127-DIN_W:0], din};
                            pcnt_d  = pcnt_d + PCW'(1);
                            if (pcnt_d == PB_C) pv_d = 1'b1;
                        end else begin
                            err_d[1] = 1'b1;
                        end
                    end
                    CMD_SK: begin
                        state_d = LOADK;
                        if (state_q != LOADK) begin
                            kcnt_d = '0;
                            kv_d   = 1'b0;
                        end
                        if (kcnt_d < KB_C) begin
                            key_d  = {key_q[KEY_W-1-DIN_W:0], din};
                            kcnt_d = kcnt_d + KCW'(1);
                            if (kcnt_d == KB_C) kv_d = 1'b1;
                        end else begin
                            err_d[1] = 1'b1;
                        end
                    end
                    CMD_ST: begin
                        if (pv_q && kv_q && transformer_done) begin
                            start_d = 1'b1;
                            state_d = BUSY_ACK;
                        end else begin
                            err_d[0] = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                endcase
            end
            BUSY_ACK: begin
                if (!transformer_done) state_d = BUSY_RUN;
            end
            BUSY_RUN: begin
                if (transformer_done) begin
                    done_d  = 1'b1;
                    pv_d    = 1'b0;
                    pcnt_d  = '0;
                    if (KEEP_KEY == 0) begin
                        kv_d   = 1'b0;
                        kcnt_d = '0;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE) || (state_d == LOADP) || (state_d == LOADK);
    end

    assign ready        = ready_q;
    assign engine_start = start_q;
    assign plain_out    = plain_q;
    assign key_out      = key_q;
    assign plain_valid  = pv_q;
    assign key_valid    = kv_q;
    assign done_pulse   = done_q;
    assign err          = err_q;

endmodule
